// File: rtl/complex_vxc_add_sequencer.sv
// Streams NOE complex elements as NI-lane chunks from row memories through the r=a*c+/-b datapath.
// Write-back trails each read by LAT+3 cycles. There is no backpressure: rows issue back-to-back.
module complex_vxc_add_sequencer #(
    parameter int NOE           = 19,
    parameter int NI            = 8,
    parameter int ELEMENT_WIDTH = 64,
    parameter int LAT           = 9,
    parameter int ADDR_W        = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_op_in,
    input  logic [ELEMENT_WIDTH-1:0]    i_constant_in,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_rd_en,
    output logic [ADDR_W-1:0]           o_rd_addr,
    input  logic [ELEMENT_WIDTH*NI-1:0] i_mem_a_data,
    input  logic [ELEMENT_WIDTH*NI-1:0] i_mem_b_data,
    output logic [ELEMENT_WIDTH*NI-1:0] o_dp_first_row,
    output logic [ELEMENT_WIDTH*NI-1:0] o_dp_second_row,
    output logic [ELEMENT_WIDTH-1:0]    o_dp_constant,
    output logic                        o_dp_op,
    input  logic [ELEMENT_WIDTH*NI-1:0] i_dp_result,
    output logic                        o_wr_en,
    output logic [ADDR_W-1:0]           o_wr_addr,
    output logic [ELEMENT_WIDTH*NI-1:0] o_wr_data,
    output logic [NI-1:0]               o_wr_mask
);

    localparam int ROW_W  = ELEMENT_WIDTH * NI;
    localparam int NCHUNK = (NOE + NI - 1) / NI;
    localparam int TAIL   = NOE - (NCHUNK - 1) * NI;
    localparam int DEPTH  = LAT + 3;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCHUNK - 1);
    // Lane 0 sits in the MSB, so the valid tail lanes are the top TAIL bits.
    localparam logic [NI-1:0] TAIL_MASK = ~({NI{1'b1}} >> TAIL);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } tag_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDR_W-1:0]        r_rd_cnt;
    logic [ELEMENT_WIDTH-1:0] r_const;
    logic                     r_op;
    tag_t                     r_tag [DEPTH];
    tag_t                     w_tag_out;
    logic [ROW_W-1:0]         r_first;
    logic [ROW_W-1:0]         r_second;
    logic [ROW_W-1:0]         r_wr_data;
    logic                     w_busy;
    logic                     w_done;
    logic                     w_rd_en;
    logic [ADDR_W-1:0]        w_rd_addr;

    assign w_tag_out = r_tag[DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_ISSUE;
            S_ISSUE: if (r_rd_cnt == LAST_ADDR) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_tag_out.vld && w_tag_out.last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_done    = (r_state == S_DONE);
        w_rd_en   = (r_state == S_ISSUE);
        w_rd_addr = w_rd_en ? r_rd_cnt : '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rd_cnt <= '0;
            r_const  <= '0;
            r_op     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_const <= i_constant_in;
                r_op    <= i_op_in;
            end
            if (r_state == S_ISSUE && r_rd_cnt != LAST_ADDR) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end else begin
                r_rd_cnt <= '0;
            end
        end
    end

    // Tag stage k is valid k+1 cycles after its read; the final stage lines up with wr_data.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= '{vld: w_rd_en, addr: w_rd_addr, last: w_rd_en && (r_rd_cnt == LAST_ADDR)};
            for (int k = 1; k < DEPTH; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_first   <= '0;
            r_second  <= '0;
            r_wr_data <= '0;
        end else begin
            if (r_tag[0].vld) begin
                r_first  <= i_mem_a_data;
                r_second <= i_mem_b_data;
            end
            if (r_tag[LAT+1].vld) begin
                r_wr_data <= i_dp_result;
            end
        end
    end

    assign o_busy          = w_busy;
    assign o_done          = w_done;
    assign o_rd_en         = w_rd_en;
    assign o_rd_addr       = w_rd_addr;
    assign o_dp_first_row  = r_first;
    assign o_dp_second_row = r_second;
    assign o_dp_constant   = r_const;
    assign o_dp_op         = r_op;
    assign o_wr_en         = w_tag_out.vld;
    assign o_wr_addr       = w_tag_out.addr;
    assign o_wr_data       = r_wr_data;
    assign o_wr_mask       = w_tag_out.vld ? (w_tag_out.last ? TAIL_MASK : {NI{1'b1}}) : '0;

endmodule
